ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative multiply/divide unit that sits beside the EX-stage ALU and writes results to HI/LO. It replaces the single-cycle combinational 32×32 multiplier with a parametrised radix-2 sequential datapath. It supports signed and unsigned multiply and divide. While an operation is in flight it stalls the pipeline through `busy_o`.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start_i`  in  1  request a new operation; sampled only in IDLE.
- `op_i`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `opdata1_i`  in  WIDTH  multiplicand or dividend.
- `opdata2_i`  in  WIDTH  multiplier or divisor.
- `annul_i`  in  1  flush (exception or branch squash); aborts the current operation.
- `busy_o`  out  1  stall request to the pipeline controller.
- `ready_o`  out  1  one-cycle pulse; `hi_o`/`lo_o` are valid during the pulse.
- `hi_o`  out  WIDTH  upper product half, or remainder.
- `lo_o`  out  WIDTH  lower product half, or quotient.
- `div_by_zero_o`  out  1  valid with `ready_o`; set when a divide had a zero divisor.

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset: state IDLE, counter 0, `ready_o`=0, `div_by_zero_o`=0, `hi_o`=`lo_o`=0.
- `busy_o` is combinational: `(state==RUN) | (state==IDLE & start_i & !annul_i)`. It is low in DONE.
- **IDLE → RUN** when `start_i` is high and `annul_i` is low:
  - Latch `op_i`.
  - For signed ops, latch the operand magnitudes.
  - Record the result signs: product/quotient sign = `sign1 ^ sign2`; remainder sign = `sign1`.
  - Clear the counter.
- **IDLE → DONE directly** for a divide with `opdata2_i`==0:
  - `lo_o` = all ones.
  - `hi_o` = `opdata1_i` unmodified.
  - `div_by_zero_o` = 1.
- **RUN, multiply**: shift-add, one multiplier bit per cycle. Uses a 2·WIDTH accumulator.
- **RUN, divide**: restoring division, one quotient bit per cycle. Uses a WIDTH+1-bit partial remainder.
- **RUN → DONE** when the counter reaches WIDTH−1 on the current edge, i.e. after WIDTH RUN cycles.
- On the RUN → DONE edge, `hi_o`/`lo_o` are loaded with the sign-corrected (two's-complement negated where needed) results.
- **DONE → IDLE** unconditionally. `ready_o`=1 only in DONE.
- `hi_o`/`lo_o` hold their values after DONE until the next DONE.
- `start_i` is ignored in RUN and DONE; no queueing.
- `annul_i` high in any state: the next state is IDLE.
  - No `ready_o` is produced.
  - `hi_o`/`lo_o` keep their previous values.
  - `annul_i` beats `start_i` in the same cycle.
- `rst` mid-operation returns all state and outputs to their reset values on the next edge.
- Most-negative operand in signed mode: handled via WIDTH-bit magnitude treated as unsigned. Example: (−2^31)·(−1) gives hi=0, lo=0x80000000. Example: DIV (−2^31)/(−1) gives lo=0x80000000, hi=0.

## Timing
- Cycle 0: `start_i` high in IDLE, `busy_o`=1.
- Cycles 1..WIDTH: RUN, `busy_o`=1.
- Cycle WIDTH+1: DONE, `ready_o`=1, `busy_o`=0, results valid.
- Total latency: start cycle to ready cycle = WIDTH+1 (33 cycles for WIDTH=32).
- Divide by zero: `ready_o` in cycle 1.
- Back-to-back: a new `start_i` is accepted in the cycle following DONE.
- All outputs except `busy_o` are registered.

## Configuration
- `MULDIV_DIV_EN` defined: divide datapath compiled in, behaviour as described above.
- `MULDIV_DIV_EN` undefined: no divider logic.
  - Ops 10/11 go IDLE → DONE with `hi_o`=`lo_o`=0 and `div_by_zero_o`=0.
  - `ready_o` in cycle 1.
  - Multiply ops are unchanged.

## Test plan
WIDTH=32 unless noted.
- MULT −3 × 5 → `ready_o` at cycle 33; `hi_o`=0xFFFFFFFF, `lo_o`=0xFFFFFFF1; `busy_o` high cycles 0–32.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi_o`=0xFFFFFFFE, `lo_o`=0x00000001.
- DIV −7 / 2 → `lo_o`=0xFFFFFFFD, `hi_o`=0xFFFFFFFF; DIVU 100 / 7 → `lo_o`=14, `hi_o`=2.
- DIVU 7 / 0 → `ready_o` at cycle 1, `div_by_zero_o`=1, `lo_o`=0xFFFFFFFF, `hi_o`=7. Without `MULDIV_DIV_EN`: `hi_o`=`lo_o`=0, `div_by_zero_o`=0.
- MULT started, `annul_i` pulsed at cycle 10 → no `ready_o`; `busy_o` low from cycle 11; `hi_o`/`lo_o` keep old values. A new MULTU 2×3 at cycle 12 → `lo_o`=6 at cycle 45.
- `rst` asserted at cycle 5 of a DIV → all outputs 0 and state IDLE after the edge. WIDTH=8: MULT 0x80 × 0xFF (−128 × −1) → `hi_o`=0x00, `lo_o`=0x80, `ready_o` at cycle 9.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative radix-2 multiply/divide unit beside the EX-stage ALU, results go to HI/LO.
// Latency: start cycle to ready_o pulse is WIDTH+1 cycles; divide shortcuts (zero divisor, or any
// divide when the divider is not built) finish in 1 cycle. busy_o stalls the pipeline while running.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start_i, op_i       request + op (00 MULTU, 01 MULT, 10 DIVU, 11 DIV), sampled only in IDLE
//   opdata1_i/2_i       multiplicand/dividend, multiplier/divisor
//   annul_i             pipeline flush; abandons any operation, wins over start_i
//   busy_o              combinational stall request
//   ready_o             one-cycle pulse, hi_o/lo_o/div_by_zero_o valid with it
//   hi_o, lo_o          product halves, or remainder/quotient; held until the next completion
//   div_by_zero_o       divide had a zero divisor
// Build option: define MULDIV_DIV_EN to compile in the restoring divider. Without it, divide ops
// complete immediately with zero results and div_by_zero_o low.

module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  input  logic             annul_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic               last;
  logic               neg_q;       // product / quotient must be negated at the end

  // Multiply datapath: multiplier sits in the low half of the accumulator and is
  // consumed one bit per cycle as partial sums shift in from the top.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH:0]     acc_sum;

  // Operand conditioning at acceptance time.
  logic               is_signed;
  logic               sign1, sign2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic               div_shortcut;

  logic [WIDTH-1:0]   res_hi, res_lo;

`ifdef MULDIV_DIV_EN
  logic               op_div_q;
  logic               rem_neg_q;   // remainder takes the dividend's sign
  logic [WIDTH-1:0]   rem_q;       // settled remainder is always below the divisor
  logic [WIDTH-1:0]   quo_q;       // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH:0]     rem_shift;   // WIDTH+1-bit partial remainder for the trial subtract
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;
`endif

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // Signed ops work on magnitudes; the most-negative value negates to itself,
  // which is its correct magnitude when read as unsigned.
  assign is_signed = op_i[0];
  assign sign1     = is_signed & opdata1_i[WIDTH-1];
  assign sign2     = is_signed & opdata2_i[WIDTH-1];
  assign mag1      = sign1 ? -opdata1_i : opdata1_i;
  assign mag2      = sign2 ? -opdata2_i : opdata2_i;

`ifdef MULDIV_DIV_EN
  assign div_shortcut = op_i[1] & (opdata2_i == '0);
`else
  assign div_shortcut = op_i[1];
`endif

  // One shift-add step.
  assign acc_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign acc_nxt = {acc_sum, acc[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  // One restoring-division step.
  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign rem_ge    = (rem_shift >= {1'b0, dvs_q});
  assign rem_nxt   = rem_ge ? WIDTH'(rem_shift - {1'b0, dvs_q}) : rem_shift[WIDTH-1:0];
  assign quo_nxt   = {quo_q[WIDTH-2:0], rem_ge};
`endif

  // Sign-corrected results from the values produced by the final step.
  always_comb begin
    {res_hi, res_lo} = neg_q ? -acc_nxt : acc_nxt;
`ifdef MULDIV_DIV_EN
    if (op_div_q) begin
      res_hi = rem_neg_q ? -rem_nxt : rem_nxt;
      res_lo = neg_q ? -quo_nxt : quo_nxt;
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and stall request.
  always_comb begin
    state_nxt = state;
    busy_o    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i && !annul_i) begin
          busy_o    = 1'b1;
          state_nxt = div_shortcut ? DONE : RUN;
        end
      end
      RUN: begin
        busy_o = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (annul_i) begin
      state_nxt = IDLE;
    end
  end

  // Datapath and registered outputs. An annulled cycle loads nothing, so
  // hi_o/lo_o keep whatever the last completed operation left there.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      ready_o       <= 1'b0;
      div_by_zero_o <= 1'b0;
      hi_o          <= '0;
      lo_o          <= '0;
      acc           <= '0;
      mcand         <= '0;
      neg_q         <= 1'b0;
`ifdef MULDIV_DIV_EN
      op_div_q      <= 1'b0;
      rem_neg_q     <= 1'b0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
`endif
    end else begin
      ready_o       <= 1'b0;
      div_by_zero_o <= 1'b0;
      if (!annul_i) begin
        case (state)
          IDLE: begin
            if (start_i) begin
              cnt <= '0;
              if (div_shortcut) begin
                ready_o <= 1'b1;
`ifdef MULDIV_DIV_EN
                hi_o          <= opdata1_i;
                lo_o          <= '1;
                div_by_zero_o <= 1'b1;
`else
                hi_o          <= '0;
                lo_o          <= '0;
`endif
              end else begin
                acc   <= {{WIDTH{1'b0}}, mag2};
                mcand <= mag1;
                neg_q <= sign1 ^ sign2;
`ifdef MULDIV_DIV_EN
                op_div_q  <= op_i[1];
                rem_neg_q <= sign1;
                rem_q     <= '0;
                quo_q     <= mag1;
                dvs_q     <= mag2;
`endif
              end
            end
          end
          RUN: begin
            cnt <= cnt + 1'b1;
            acc <= acc_nxt;
`ifdef MULDIV_DIV_EN
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
`endif
            if (last) begin
              ready_o <= 1'b1;
              hi_o    <= res_hi;
              lo_o    <= res_lo;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed cases with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_ex_muldiv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, annul;
  logic [1:0]  op;
  logic [31:0] d1, d2;
  logic        busy, ready, dbz;
  logic [31:0] hi, lo;

  logic        s8, an8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, ready8, dbz8;
  logic [7:0]  hi8, lo8;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .opdata1_i(d1), .opdata2_i(d2),
    .annul_i(annul), .busy_o(busy), .ready_o(ready), .hi_o(hi), .lo_o(lo),
    .div_by_zero_o(dbz)
  );

  ex_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(s8), .op_i(op8), .opdata1_i(a8), .opdata2_i(b8),
    .annul_i(an8), .busy_o(busy8), .ready_o(ready8), .hi_o(hi8), .lo_o(lo8),
    .div_by_zero_o(dbz8)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endfunction

  // Architectural result of one operation, straight from the arithmetic definition.
  function automatic void model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l,
                                output bit z, output bit imm);
    logic [63:0] pu;
    longint      sa, sb, ps, q, r;
    z = 1'b0; imm = 1'b0; h = '0; l = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (mop)
      2'b00: begin pu = {32'd0, a} * {32'd0, b}; h = pu[63:32]; l = pu[31:0]; end
      2'b01: begin ps = sa * sb; h = ps[63:32]; l = ps[31:0]; end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) begin
          imm = 1'b1; z = 1'b1; h = a; l = 32'hFFFF_FFFF;
        end else if (mop == 2'b10) begin
          l = a / b; h = a % b;
        end else begin
          q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0];
        end
`else
        imm = 1'b1;
`endif
      end
    endcase
  endfunction

  // Cycle-level model: an op in flight counts down its remaining run cycles.
  bit          m_pend, m_ready, m_dbz;
  int          m_remain;
  logic [31:0] m_hi, m_lo, r_hi, r_lo;
  bit          r_dbz, r_imm;

  always @(posedge clk) begin
    if (rst) begin
      m_pend = 0; m_ready = 0; m_dbz = 0; m_hi = '0; m_lo = '0;
    end else if (annul) begin
      m_pend = 0; m_ready = 0; m_dbz = 0;
    end else if (m_ready) begin
      m_ready = 0; m_dbz = 0;
    end else if (m_pend) begin
      m_remain--;
      if (m_remain == 0) begin
        m_pend = 0; m_ready = 1; m_hi = r_hi; m_lo = r_lo; m_dbz = r_dbz;
      end
    end else if (start) begin
      model(op, d1, d2, r_hi, r_lo, r_dbz, r_imm);
      if (r_imm) begin
        m_ready = 1; m_hi = r_hi; m_lo = r_lo; m_dbz = r_dbz;
      end else begin
        m_pend = 1; m_remain = 32;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",  {31'd0, busy},  {31'd0, m_pend || (!m_ready && start && !annul)});
      chk("ready", {31'd0, ready}, {31'd0, m_ready});
      chk("dbz",   {31'd0, dbz},   {31'd0, m_ready && m_dbz});
      chk("hi",    hi, m_hi);
      chk("lo",    lo, m_lo);
    end
  end

  // Issue one op at the next cycle, return the cycle of ready_o (-1 on timeout).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcyc, output logic [31:0] h,
                        output logic [31:0] l, output logic z);
    @(posedge clk); #1;
    start = 1'b1; op = o; d1 = a; d2 = b;
    lat = -1; bcyc = 0; h = '0; l = '0; z = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy) bcyc++;
      if (ready) begin
        lat = c; h = hi; l = lo; z = dbz;
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                      output int lat, output logic [7:0] h, output logic [7:0] l);
    @(posedge clk); #1;
    s8 = 1'b1; op8 = o; a8 = a; b8 = b;
    lat = -1; h = '0; l = '0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (ready8) begin
        lat = c; h = hi8; l = lo8;
        break;
      end
      @(posedge clk); #1;
      s8 = 1'b0;
    end
    s8 = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  int          lat, bc;
  logic [31:0] h, l, ph, pl;
  logic        z;
  bit          zb, ib;
  logic [7:0]  h8, l8;

  initial begin
    rst = 1'b1; start = 1'b0; annul = 1'b0; op = 2'b00; d1 = '0; d2 = '0;
    s8 = 1'b0; an8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; chk_en = 1'b1;

    @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Pin the model with hand-computed values.
    model(2'b01, 32'hFFFF_FFFD, 32'd5, h, l, zb, ib);
    chk("pin_mult_hi", h, 32'hFFFF_FFFF);
    chk("pin_mult_lo", l, 32'hFFFF_FFF1);
    model(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, h, l, zb, ib);
    chk("pin_mostneg_hi", h, 32'h0);
    chk("pin_mostneg_lo", l, 32'h8000_0000);
`ifdef MULDIV_DIV_EN
    model(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, h, l, zb, ib);
    chk("pin_div_mostneg_lo", l, 32'h8000_0000);
    chk("pin_div_mostneg_hi", h, 32'h0);
`endif

    run_op(2'b01, 32'hFFFF_FFFD, 32'd5, lat, bc, h, l, z);
    chk("mult_lat", lat, 33);
    chk("mult_busy_cycles", bc, 33);
    chk("mult_hi", h, 32'hFFFF_FFFF);
    chk("mult_lo", l, 32'hFFFF_FFF1);

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, h, l, z);
    chk("multu_hi", h, 32'hFFFF_FFFE);
    chk("multu_lo", l, 32'h0000_0001);

    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, h, l, z);
    chk("mult_mostneg_hi", h, 32'h0);
    chk("mult_mostneg_lo", l, 32'h8000_0000);

    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat, bc, h, l, z);
`ifdef MULDIV_DIV_EN
    chk("div_lat", lat, 33);
    chk("div_lo", l, 32'hFFFF_FFFD);
    chk("div_hi", h, 32'hFFFF_FFFF);
`else
    chk("div_lat", lat, 1);
    chk("div_lo", l, 32'h0);
    chk("div_hi", h, 32'h0);
`endif

    run_op(2'b10, 32'd100, 32'd7, lat, bc, h, l, z);
`ifdef MULDIV_DIV_EN
    chk("divu_lo", l, 32'd14);
    chk("divu_hi", h, 32'd2);
`else
    chk("divu_lo", l, 32'd0);
    chk("divu_hi", h, 32'd0);
`endif

    run_op(2'b10, 32'd7, 32'd0, lat, bc, h, l, z);
    chk("dbz_lat", lat, 1);
`ifdef MULDIV_DIV_EN
    chk("dbz_flag", {31'd0, z}, 32'd1);
    chk("dbz_lo", l, 32'hFFFF_FFFF);
    chk("dbz_hi", h, 32'd7);
`else
    chk("dbz_flag", {31'd0, z}, 32'd0);
    chk("dbz_lo", l, 32'd0);
    chk("dbz_hi", h, 32'd0);
`endif

    // Load known results, then annul a MULT at cycle 10.
    run_op(2'b00, 32'd11, 32'd13, lat, bc, ph, pl, z);
    chk("pre_annul_lo", pl, 32'd143);
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01; d1 = 32'd1234; d2 = 32'd5678;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(posedge clk); #1 annul = 1'b1;
    @(posedge clk); #1 annul = 1'b0;
    @(negedge clk);
    chk("annul_busy", {31'd0, busy}, 32'd0);
    chk("annul_ready", {31'd0, ready}, 32'd0);
    chk("annul_hi_kept", hi, ph);
    chk("annul_lo_kept", lo, pl);
    run_op(2'b00, 32'd2, 32'd3, lat, bc, h, l, z);
    chk("post_annul_lat", lat, 33);
    chk("post_annul_lo", l, 32'd6);

    // Synchronous reset at cycle 5 of a DIV.
    @(posedge clk); #1;
    start = 1'b1; op = 2'b11; d1 = 32'hFFFF_FF9C; d2 = 32'd7;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    chk("midrst_dbz", {31'd0, dbz}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    run_op(2'b01, 32'd9, 32'hFFFF_FFFF, lat, bc, h, l, z);
    chk("post_rst_lat", lat, 33);
    chk("post_rst_lo", l, 32'hFFFF_FFF7);

    // Randomized traffic: stray starts, occasional flushes and resets.
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      op    = 2'($urandom_range(0, 3));
      d1    = pick();
      d2    = pick();
      annul = ($urandom_range(0, 79) == 0);
      rst   = ($urandom_range(0, 999) == 0);
    end
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0; rst = 1'b0;
    repeat (40) @(posedge clk);

    // Narrow instance: most-negative magnitude and full-scale unsigned.
    run8(2'b01, 8'h80, 8'hFF, lat, h8, l8);
    chk("w8_mult_lat", lat, 9);
    chk("w8_mult_hi", {24'd0, h8}, 32'h00);
    chk("w8_mult_lo", {24'd0, l8}, 32'h80);
    run8(2'b00, 8'hFF, 8'hFF, lat, h8, l8);
    chk("w8_multu_hi", {24'd0, h8}, 32'hFE);
    chk("w8_multu_lo", {24'd0, l8}, 32'h01);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
